wb_port_arbiter: RTL

Arbiter for the single register-file write port, shared between the in-order pipeline write-back result and the multi-cycle long-latency unit (multiply/divide). Long-unit results are buffered in a small pending queue and written in cycles where write-back has no write. A starvation counter forces a bubble when the pipeline keeps the port busy too long. The block sits between the write-back stage mux and the register file, and exports a pending-write mask to the hazard unit.

---
 rtl/wb_arb_pkg.sv | 25 ++
 rtl/wb_pend_fifo.sv | 81 ++++++++
 rtl/wb_port_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter: entry layout,
// arbiter state encoding and a register decode helper.
package wb_arb_pkg;

    localparam int REG_W    = 3;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 1 << REG_W;

    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } pend_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// Circular queue of long-unit results awaiting a write-port slot, with
// per-register kill and the pending-register mask for the hazard unit.
module wb_pend_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  pend_entry_t               push_entry,
    input  logic                      pop,
    input  logic                      kill,
    input  logic [REG_W-1:0]          kill_reg,
    output pend_entry_t               head,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic [NUM_REGS-1:0]       pend_mask
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DEPTH-1:0]  live;
    logic [REG_W-1:0]  rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            live   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // A pushed entry never matches kill_reg: same-register pushes are dropped upstream.
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (AW'(i) == wr_ptr))
                    live[i] <= push_entry.live;
                else if (pop && (AW'(i) == rd_ptr))
                    live[i] <= 1'b0;
                else if (kill && (rd_mem[i] == kill_reg))
                    live[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= push_entry.rd;
            data_mem[wr_ptr] <= push_entry.data;
        end
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        head.live = live[rd_ptr];
        head.rd   = rd_mem[rd_ptr];
        head.data = data_mem[rd_ptr];
    end

    // A write-back to the register retires its hazard in the same cycle.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && !(kill && (rd_mem[i] == kill_reg)))
                pend_mask = pend_mask | reg_onehot(rd_mem[i]);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline write-back
// and queued long-unit results, forcing a bubble when the queue head starves.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic [REG_W-1:0]      wb_reg,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  lu_valid,
    input  logic [REG_W-1:0]      lu_reg,
    input  logic [DATA_W-1:0]     lu_data,
    output logic                  lu_ready,
    output logic                  rf_we,
    output logic [REG_W-1:0]      rf_reg,
    output logic [DATA_W-1:0]     rf_data,
    output logic                  stall_req,
    output logic [NUM_REGS-1:0]   pend_mask,
    output logic                  arb_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX) + 1;

    arb_state_t    state;
    arb_state_t    state_next;
    logic [CW-1:0] starve_cnt;
    pend_entry_t   head;
    pend_entry_t   push_entry;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic [AW:0]   occ_next;
    logic          forcing;
    logic          wb_eff;
    logic          drop;
    logic          push;
    logic          pop;
    logic          starve_hit;

    // In FORCE the write-back write is discarded, so it neither kills nor drops.
    assign forcing    = (state == FORCE);
    assign wb_eff     = wb_valid && !forcing;
    assign drop       = wb_eff && (wb_reg == lu_reg);
    assign lu_ready   = !full;
    assign push       = lu_valid && !full && !drop;
    assign pop        = !empty && (forcing || !wb_valid || !head.live);
    assign occ_next   = count + (AW+1)'(push) - (AW+1)'(pop);
    assign starve_hit = !empty && !pop && (starve_cnt == CW'(STARVE_MAX - 1));

    always_comb begin
        push_entry.live = 1'b1;
        push_entry.rd   = lu_reg;
        push_entry.data = lu_data;
    end

    wb_pend_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill       (wb_eff),
        .kill_reg   (wb_reg),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .pend_mask  (pend_mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (push) state_next = PEND;
            PEND: begin
                if (occ_next == '0)  state_next = IDLE;
                else if (starve_hit) state_next = FORCE;
            end
            FORCE:   state_next = (occ_next == '0) ? IDLE : PEND;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall_req = (state == FORCE);
        rf_we     = 1'b0;
        rf_reg    = wb_reg;
        rf_data   = wb_data;
        if (forcing || !wb_valid) begin
            rf_we   = head.live;
            rf_reg  = head.rd;
            rf_data = head.data;
        end else begin
            rf_we   = 1'b1;
        end
        if (rst) rf_we = 1'b0;
    end

    // Counts cycles the current head has waited unwritten; any pop restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                starve_cnt <= '0;
        else if (pop || empty)  starve_cnt <= '0;
        else                    starve_cnt <= starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      arb_err <= 1'b0;
        else if (forcing && wb_valid) arb_err <= 1'b1;
    end

endmodule
